// File: rtl/zap_dmem_pkg.sv
// Shared definitions for the zap data-memory bridge: FSM state encoding, the word-align mask,
// and the address range check.
package zap_dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } dmem_state_e;

    localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

    // Widened to 33 bits so a word near the top of the address space cannot wrap into range.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        logic [32:0] base;
        base = {1'b0, addr & WordMask};
        return (base >= {1'b0, lo}) && ((base + 33'd3) <= {1'b0, hi});
    endfunction

endpackage

// File: rtl/zap_dmem_timeout.sv
// Loadable down-counter that flags expiry of the memory wait window.
// Instantiated by zap_dmem_bridge only when ZAP_DMEM_TIMEOUT_EN is defined.
module zap_dmem_timeout #(
    parameter int unsigned CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Loaded with CYCLES-1 so expiry lands on the CYCLES-th running cycle.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CntW'(CYCLES - 1);
        end else if (run) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end else begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && (count_q == '0);

endmodule

// File: rtl/zap_dmem_bridge.sv
// Data-side bridge from the zap memory stage to a req/ack single-port memory with range-check aborts.
// Optional wait-state timeout abort is enabled by defining ZAP_DMEM_TIMEOUT_EN.
module zap_dmem_bridge
    import zap_dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_LO        = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI        = 32'h0000_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_address,
    input  logic [3:0]  i_ben,
    input  logic [31:0] i_wr_data,
    output logic        o_data_stall,
    output logic        o_data_abort,
    output logic [31:0] o_rd_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_ben,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic        i_mem_err,
    input  logic [31:0] i_mem_rdata
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    dmem_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic [3:0]  ben_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        abort_q, abort_d;
    logic [31:0] rd_data_q;

    logic access;
    logic latch_en;
    logic rd_load;
    logic stall;
    logic mem_req;
    logic timeout_expired;

    assign access = i_read_en | i_write_en;

`ifdef ZAP_DMEM_TIMEOUT_EN
    zap_dmem_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .load    (state_q == StReq),
        .run     (state_q == StWait),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        abort_d  = abort_q;
        latch_en = 1'b0;
        rd_load  = 1'b0;
        stall    = 1'b0;
        mem_req  = 1'b0;
        case (state_q)
            StIdle: begin
                stall = access;
                if (access) begin
                    if (addr_in_range(i_address, ADDR_LO, ADDR_HI)) begin
                        latch_en = 1'b1;
                        abort_d  = 1'b0;
                        state_d  = StReq;
                    end else begin
                        abort_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StReq: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                // Bus error outranks ack; timeout only matters when neither arrived.
                if (i_mem_err) begin
                    abort_d = 1'b1;
                    state_d = StDone;
                end else if (i_mem_ack) begin
                    rd_load = ~we_q;
                    abort_d = 1'b0;
                    state_d = StDone;
                end else if (timeout_expired) begin
                    abort_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= StIdle;
            abort_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            if (rd_load) begin
                rd_data_q <= i_mem_rdata;
            end
        end
    end

    // A simultaneous read+write is carried out as a write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_q  <= '0;
            ben_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= i_address & WordMask;
            ben_q   <= i_write_en ? i_ben : 4'hF;
            wdata_q <= i_wr_data;
            we_q    <= i_write_en;
        end
    end

    // Stall is masked by reset so the core is released the instant reset asserts.
    assign o_data_stall = stall & i_reset_n;
    assign o_data_abort = (state_q == StDone) & abort_q;
    assign o_rd_data    = rd_data_q;
    assign o_mem_req    = mem_req;
    assign o_mem_we     = mem_req & we_q;
    assign o_mem_addr   = mem_req ? addr_q : '0;
    assign o_mem_ben    = mem_req ? ben_q : '0;
    assign o_mem_wdata  = mem_req ? wdata_q : '0;

endmodule

// File: tb/tb_zap_dmem_bridge.sv
// Directed bench for zap_dmem_bridge: a transaction-timeline model predicts every output each cycle.
// Define ZAP_DMEM_TIMEOUT_EN for both RTL and bench to exercise the timeout build.
module tb_zap_dmem_bridge;

    localparam logic [31:0] Lo = 32'h0000_0000;
    localparam logic [31:0] Hi = 32'h0000_FFFF;
    localparam int unsigned To = 8;
`ifdef ZAP_DMEM_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic [3:0]  ben = '0;
    logic        mem_ack = 1'b0, mem_err = 1'b0;
    logic        data_stall, data_abort, mem_req, mem_we;
    logic [31:0] rd_data, mem_addr, mem_wdata;
    logic [3:0]  mem_ben;

    zap_dmem_bridge #(
        .ADDR_LO        (Lo),
        .ADDR_HI        (Hi),
        .TIMEOUT_CYCLES (To)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_read_en    (rd_en),
        .i_write_en   (wr_en),
        .i_address    (addr),
        .i_ben        (ben),
        .i_wr_data    (wdata),
        .o_data_stall (data_stall),
        .o_data_abort (data_abort),
        .o_rd_data    (rd_data),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_ben    (mem_ben),
        .o_mem_wdata  (mem_wdata),
        .i_mem_ack    (mem_ack),
        .i_mem_err    (mem_err),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Per-cycle expectations, set by the stimulus and consumed on the falling edge.
    bit          chk_en = 1'b0;
    bit          exp_stall, exp_req, exp_we, exp_abort, chk_wdata;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_ben;
    logic [31:0] rd_model = '0;

    // Running statistics for the literal checks.
    int          stall_cnt = 0, req_cnt = 0, abort_cnt = 0;
    logic [31:0] seen_addr = '0;
    logic [3:0]  seen_ben = '0;
    bit          seen_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("stall", 32'(data_stall), 32'(exp_stall));
                chk("mem_req", 32'(mem_req), 32'(exp_req));
                chk("abort", 32'(data_abort), 32'(exp_abort));
                chk("rd_data", rd_data, exp_rd);
                if (exp_req) begin
                    chk("mem_we", 32'(mem_we), 32'(exp_we));
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_ben", 32'(mem_ben), 32'(exp_ben));
                    if (chk_wdata) chk("mem_wdata", mem_wdata, exp_wdata);
                end
                if (data_stall) stall_cnt++;
                if (data_abort) abort_cnt++;
                if (mem_req) begin
                    req_cnt++;
                    seen_addr = mem_addr;
                    seen_ben  = mem_ben;
                    seen_we   = mem_we;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        exp_abort = 1'b0;
        exp_rd    = rd_model;
    endtask

    // n = cycle offset of the accepted ack/err after the REQ cycle (number of WAIT cycles).
    task automatic do_access(input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] wd, input int n, input bit err, input bit ack,
                             input bit early, input logic [31:0] rdat);
        longint base;
        bit     legal, timed_out, ab;
        int     n_wait;
        base      = longint'(a) & 64'hFFFF_FFFC;
        legal     = (base >= longint'(Lo)) && (base + 3 <= longint'(Hi));
        timed_out = TimeoutEn && (n > int'(To));
        n_wait    = timed_out ? int'(To) : n;
        ab        = !legal || timed_out || err;
        rd_en = r; wr_en = w; addr = a; ben = b; wdata = wd;
        set_idle_exp();
        exp_stall = 1'b1;
        step();
        if (legal) begin
            exp_req = 1'b1; exp_stall = 1'b1;
            exp_we = w; exp_addr = a & 32'hFFFF_FFFC; exp_ben = w ? b : 4'hF;
            exp_wdata = wd; chk_wdata = w;
            if (early) begin mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
            step();
            mem_ack = 1'b0;
            for (int k = 1; k <= n_wait; k++) begin
                if (k == n_wait && !timed_out) begin
                    mem_ack = ack; mem_err = err; mem_rdata = rdat;
                end
                step();
                mem_ack = 1'b0; mem_err = 1'b0;
            end
        end
        if (legal && !ab && r && !w) rd_model = rdat;
        set_idle_exp();
        exp_abort = ab;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        set_idle_exp();
        step();
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        #1;
        chk("rst_stall", 32'(data_stall), 32'd0);
        chk("rst_abort", 32'(data_abort), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_ben", 32'(mem_ben), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_idle_exp();
        chk_en = 1'b1;
        step();

        // 1: read 0x100, ack two cycles after REQ.
        stall_cnt = 0;
        do_access(1, 0, 32'h100, 4'h0, 32'h0, 2, 0, 1, 0, 32'hDEAD_BEEF);
        chk("t1_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("t1_rd_lit", rd_data, 32'hDEAD_BEEF);

        // 2: unaligned write.
        do_access(0, 1, 32'h203, 4'b0011, 32'h1234, 1, 0, 1, 0, 32'h0);
        chk("t2_addr_lit", seen_addr, 32'h200);
        chk("t2_ben_lit", 32'(seen_ben), 32'h3);
        chk("t2_we_lit", 32'(seen_we), 32'd1);

        // 3: just above ADDR_HI.
        req_cnt = 0; abort_cnt = 0;
        do_access(1, 0, 32'h1_0000, 4'h0, 32'h0, 1, 0, 1, 0, 32'h0);
        chk("t3_no_req", 32'(req_cnt), 32'd0);
        chk("t3_abort_seen", 32'(abort_cnt), 32'd1);

        // 4: err and ack together.
        abort_cnt = 0;
        do_access(1, 0, 32'h300, 4'h0, 32'h0, 3, 1, 1, 0, 32'h5555_AAAA);
        chk("t4_abort_seen", 32'(abort_cnt), 32'd1);
        chk("t4_rd_kept", rd_data, 32'hDEAD_BEEF);

        // Boundary word, stray ack in REQ ignored; read+write treated as write; wrapping address.
        do_access(1, 0, 32'hFFFC, 4'h0, 32'h0, 2, 0, 1, 1, 32'hCAFE_F00D);
        chk("edge_rd_lit", rd_data, 32'hCAFE_F00D);
        do_access(0, 1, 32'hFFFE, 4'b1100, 32'hA5A5_0000, 1, 0, 1, 0, 32'h0);
        do_access(1, 1, 32'h80, 4'hF, 32'h0000_A5A5, 1, 0, 1, 0, 32'h1111_1111);
        chk("rw_rd_kept", rd_data, 32'hCAFE_F00D);
        do_access(1, 0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1, 0, 1, 0, 32'h0);
        do_access(0, 1, 32'h1_0002, 4'hF, 32'h0, 1, 0, 1, 0, 32'h0);

        // 5: reset during WAIT, then a stray ack.
        chk_en = 1'b0;
        rd_en = 1'b1; addr = 32'h40;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        chk("t5_stall_drop", 32'(data_stall), 32'd0);
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_model = '0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        chk("t5_idle_req", 32'(mem_req), 32'd0);
        chk("t5_idle_stall", 32'(data_stall), 32'd0);
        chk("t5_rd_clear", rd_data, 32'd0);
        step();
        chk("t5_idle_req2", 32'(mem_req), 32'd0);
        set_idle_exp();
        chk_en = 1'b1;
        step();

        // 6: ack withheld for 100 WAIT cycles.
        stall_cnt = 0; abort_cnt = 0;
        do_access(1, 0, 32'h500, 4'h0, 32'h0, 101, 0, 1, 0, 32'h0BAD_F00D);
        if (TimeoutEn) begin
            chk("t6_stall_cycles", 32'(stall_cnt), 32'(To + 2));
            chk("t6_abort_seen", 32'(abort_cnt), 32'd1);
        end else begin
            chk("t6_stall_cycles", 32'(stall_cnt), 32'd103);
            chk("t6_rd_lit", rd_data, 32'h0BAD_F00D);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
